// File: rtl/test_rr_arb_merge.sv
// rtl/test_rr_arb_merge.sv - round-robin val/rdy merge of p_num_reqs requesters onto one tagged output channel
// Optional macro VC_TEST_ARB_RAND_GAP_EN adds random idle gaps (0..p_max_gap cycles) after each transfer.
module test_rr_arb_merge #(
  parameter int p_msg_sz   = 8,
  parameter int p_num_reqs = 4,
  parameter int p_id_sz    = 2,
  parameter int p_max_gap  = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [p_num_reqs-1:0]          in_val,
  output logic [p_num_reqs-1:0]          in_rdy,
  input  logic [p_num_reqs*p_msg_sz-1:0] in_msg,
  output logic                           out_val,
  input  logic                           out_rdy,
  output logic [p_msg_sz-1:0]            out_msg,
  output logic [p_id_sz-1:0]             out_src
);

  localparam int n_slots = 1 << p_id_sz;
  localparam logic [p_id_sz-1:0] last_id = p_id_sz'(p_num_reqs - 1);

  if (p_num_reqs < 2 || p_num_reqs > 16 || p_num_reqs > n_slots || p_max_gap < 0) begin : g_bad_cfg
    $error("test_rr_arb_merge: illegal parameter combination");
  end

`ifdef VC_TEST_ARB_RAND_GAP_EN
  typedef enum logic [1:0] {IDLE, LOCK, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOCK} state_t;
`endif

  state_t               state, state_n;
  logic [p_id_sz-1:0]   ptr, ptr_n;
  logic [p_id_sz-1:0]   gnt_id, gnt_n;
  logic [p_id_sz-1:0]   sel, cur;
  logic                 any_val;
  logic                 rdy_en;
  logic                 xfer;

  // Requesters padded out to the full id space so p_id_sz-wide indices never run off the end.
  logic [n_slots-1:0]   val_pad;
  logic [p_msg_sz-1:0]  msg_arr [n_slots];

  for (genvar g = 0; g < n_slots; g++) begin : g_pad
    if (g < p_num_reqs) begin : g_real
      assign val_pad[g] = in_val[g];
      assign msg_arr[g] = in_msg[g*p_msg_sz +: p_msg_sz];
    end else begin : g_fill
      assign val_pad[g] = 1'b0;
      assign msg_arr[g] = '0;
    end
  end

  function automatic logic [p_id_sz-1:0] next_id(input logic [p_id_sz-1:0] id);
    return (id == last_id) ? '0 : id + p_id_sz'(1);
  endfunction

  // First valid requester searching upward from ptr with wrap at p_num_reqs.
  always_comb begin
    logic [p_id_sz:0] sum;
    sel     = '0;
    any_val = 1'b0;
    sum     = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      sum = {1'b0, ptr} + (p_id_sz+1)'(k);
      if (sum >= (p_id_sz+1)'(p_num_reqs))
        sum = sum - (p_id_sz+1)'(p_num_reqs);
      if (!any_val && val_pad[sum[p_id_sz-1:0]]) begin
        sel     = sum[p_id_sz-1:0];
        any_val = 1'b1;
      end
    end
  end

  always_comb begin
    cur     = (state == LOCK) ? gnt_id : sel;
    out_val = 1'b0;
    rdy_en  = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        out_val = any_val;
        rdy_en  = any_val;
      end else if (state == LOCK) begin
        out_val = val_pad[gnt_id];
        rdy_en  = 1'b1;
      end
    end
    out_msg = msg_arr[cur];
    out_src = cur;
    xfer    = out_val && out_rdy;
  end

  for (genvar g = 0; g < p_num_reqs; g++) begin : g_rdy
    assign in_rdy[g] = rdy_en && out_rdy && (cur == p_id_sz'(g));
  end

`ifdef VC_TEST_ARB_RAND_GAP_EN
  logic [31:0] gap_cnt;
  logic [31:0] gap_draw;

  // The gap for the next transfer is drawn in advance so the FSM can branch on it combinationally.
  always_ff @(posedge clk) begin
    if (reset || xfer)
      gap_draw <= {$random} % 32'(p_max_gap + 1);
  end

  always_ff @(posedge clk) begin
    if (reset)
      gap_cnt <= '0;
    else if (xfer)
      gap_cnt <= gap_draw;
    else if (state == GAP && gap_cnt != '0)
      gap_cnt <= gap_cnt - 32'd1;
  end
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt_id;
    case (state)
      IDLE: begin
        if (any_val) begin
          if (out_rdy) begin
            ptr_n = next_id(sel);
`ifdef VC_TEST_ARB_RAND_GAP_EN
            state_n = (gap_draw != '0) ? GAP : IDLE;
`else
            state_n = IDLE;
`endif
          end else begin
            gnt_n   = sel;
            state_n = LOCK;
          end
        end
      end
      LOCK: begin
        // A requester withdrawing its valid while locked releases the lock without a transfer.
        if (!val_pad[gnt_id]) begin
          state_n = IDLE;
        end else if (out_rdy) begin
          ptr_n = next_id(gnt_id);
`ifdef VC_TEST_ARB_RAND_GAP_EN
          state_n = (gap_draw != '0) ? GAP : IDLE;
`else
          state_n = IDLE;
`endif
        end
      end
`ifdef VC_TEST_ARB_RAND_GAP_EN
      GAP: begin
        if (gap_cnt <= 32'd1)
          state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      ptr    <= '0;
      gnt_id <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      gnt_id <= gnt_n;
    end
  end

endmodule

// File: tb/tb_test_rr_arb_merge.sv
// tb/tb_test_rr_arb_merge.sv - randomized bench for test_rr_arb_merge against a behavioural round-robin model
module tb_test_rr_arb_merge;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int ID = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     in_val = '0;
  logic [N-1:0]     in_rdy;
  logic [N*W-1:0]   in_msg = '0;
  logic             out_val;
  logic             out_rdy = 1'b0;
  logic [W-1:0]     out_msg;
  logic [ID-1:0]    out_src;

  test_rr_arb_merge #(.p_msg_sz(W), .p_num_reqs(N), .p_id_sz(ID), .p_max_gap(0)) dut (
    .clk(clk), .reset(reset),
    .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
    .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg), .out_src(out_src)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] msg [N];
  int           m_ptr  = 0;
  int           m_lock = -1;   // -1: not locked, else locked requester index
  int           xfer_q[$];

  logic         a_val;
  logic [N-1:0] a_rdy;
  int           a_src;
  logic [W-1:0] a_msg;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive on the falling edge, compare against the model, then advance the model at the rising edge.
  task automatic step(input logic r, input logic [N-1:0] v, input logic o);
    logic         ev;
    logic [N-1:0] er;
    int           es;
    @(negedge clk);
    reset   = r;
    in_val  = v;
    out_rdy = o;
    for (int i = 0; i < N; i++) in_msg[i*W +: W] = msg[i];
    #1;
    ev = 1'b0;
    er = '0;
    es = -1;
    if (!r) begin
      if (m_lock >= 0) es = m_lock;
      else
        for (int k = 0; k < N; k++)
          if (es < 0 && v[(m_ptr + k) % N]) es = (m_ptr + k) % N;
      if (es >= 0) begin
        ev = (m_lock >= 0) ? v[es] : 1'b1;
        if (o) er[es] = 1'b1;
      end
    end
    check("out_val", 32'(out_val), 32'(ev));
    check("in_rdy", 32'(in_rdy), 32'(er));
    if (ev) begin
      check("out_src", 32'(out_src), es);
      check("out_msg", 32'(out_msg), 32'(msg[es]));
    end
    a_val = out_val;
    a_rdy = in_rdy;
    a_src = int'(out_src);
    a_msg = out_msg;
    @(posedge clk);
    if (r) begin
      m_ptr  = 0;
      m_lock = -1;
    end else if (ev && o) begin
      m_ptr  = (es + 1) % N;
      m_lock = -1;
      xfer_q.push_back(es);
    end else if (m_lock >= 0 && !v[m_lock]) begin
      m_lock = -1;
    end else if (m_lock < 0 && ev) begin
      m_lock = es;
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) msg[i] = 8'(8'h11 * i);

    // Reset dominates the inputs.
    repeat (2) begin
      step(1'b1, 4'b1111, 1'b1);
      check("reset_val", 32'(a_val), 32'd0);
      check("reset_rdy", 32'(a_rdy), 32'd0);
    end
    step(1'b0, 4'b0000, 1'b1);
    check("idle_val", 32'(a_val), 32'd0);
    check("idle_rdy", 32'(a_rdy), 32'd0);

    // All valid, always ready: strict rotation with zero-cycle latency.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'b1111, 1'b1);
      check("rr_src", a_src, i % 4);
      check("rr_msg", 32'(a_msg), 32'h11 * (i % 4));
      check("rr_rdy", 32'(a_rdy), 32'(1 << (i % 4)));
    end
    check("rr_xfer_count", xfer_q.size(), 8);

    // Lock on 2 while stalled; a higher-priority newcomer must not steal the grant.
    step(1'b0, 4'b0100, 1'b0);
    check("lock_src", a_src, 2);
    check("lock_rdy", 32'(a_rdy), 32'd0);
    repeat (2) begin
      step(1'b0, 4'b0101, 1'b0);
      check("lock_hold_src", a_src, 2);
      check("lock_hold_val", 32'(a_val), 32'd1);
    end
    step(1'b0, 4'b0101, 1'b1);
    check("lock_xfer_src", a_src, 2);
    check("lock_xfer_msg", 32'(a_msg), 32'h22);
    check("lock_xfer_rdy", 32'(a_rdy), 32'b0100);
    step(1'b0, 4'b0101, 1'b1);
    check("wrap_after_lock", a_src, 0);

    // Pointer to 3, then 3 and 0 both valid: 3 first, then 0 by wrap.
    step(1'b0, 4'b0100, 1'b1);
    check("to_ptr3", a_src, 2);
    step(1'b0, 4'b1001, 1'b1);
    check("ptr3_first", a_src, 3);
    step(1'b0, 4'b1001, 1'b1);
    check("ptr3_wrap", a_src, 0);

    // Locked on 1, valid withdrawn: no transfer, pointer stays at 1.
    step(1'b0, 4'b0010, 1'b0);
    check("drop_lock_src", a_src, 1);
    step(1'b0, 4'b0000, 1'b1);
    check("drop_val", 32'(a_val), 32'd0);
    check("drop_rdy", 32'(a_rdy), 32'b0010);
    step(1'b0, 4'b1111, 1'b1);
    check("drop_ptr_kept", a_src, 1);

    // Reset while locked abandons the lock.
    step(1'b0, 4'b0100, 1'b0);
    step(1'b1, 4'b1111, 1'b1);
    check("mid_reset_val", 32'(a_val), 32'd0);
    step(1'b0, 4'b1111, 1'b1);
    check("post_reset_src", a_src, 0);

    // Random traffic, stalls, withdrawals and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) msg[i] = 8'($urandom);
      step($urandom_range(0, 99) == 0, 4'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/test_rr_arb_merge.md
Name: test_rr_arb_merge

Overview:
Round-robin arbiter that shares one val/rdy output channel among p_num_reqs val/rdy test requesters. It tags each forwarded message with the winner's index. It sits between several test sources (or random-delay stages) and one DUT input port. A grant, once issued, is locked until the message transfers, so a stalled output never causes a message to be dropped or switched.

Parameters:
p_msg_sz, 8, message width in bits
p_num_reqs, 4, number of requesters; legal range 2..16
p_id_sz, 2, width of out_src; must satisfy p_num_reqs <= 2**p_id_sz
p_max_gap, 0, maximum idle cycles inserted after a transfer (used only with the optional feature)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_val  in  p_num_reqs  per-requester valid; bit i belongs to requester i
in_rdy  out  p_num_reqs  per-requester ready
in_msg  in  p_num_reqs*p_msg_sz  requester i occupies bits [i*p_msg_sz +: p_msg_sz]
out_val  out  1  output valid
out_rdy  in  1  output ready
out_msg  out  p_msg_sz  message from the granted requester
out_src  out  p_id_sz  index of the granted requester

Behaviour:
- Interface: clock clk; reset reset, synchronous, active-high.
- State: FSM {IDLE, LOCK, GAP}, priority pointer ptr (p_id_sz bits), locked id gnt_id.
- Reset: state=IDLE, ptr=0, gnt_id=0. While reset is high, out_val=0 and in_rdy=0 regardless of inputs.
- Transfer: occurs when out_val && out_rdy. At most one transfer per cycle.
- IDLE:
  - sel = first i with in_val[i]=1, searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - If any in_val is high: out_val=1, out_msg=in_msg[sel], out_src=sel, in_rdy[sel]=out_rdy, all other in_rdy=0.
  - If out_rdy=1 (zero-cycle path): ptr<=(sel+1) mod N; state<=IDLE, or GAP if a gap is drawn.
  - If out_rdy=0: gnt_id<=sel, state<=LOCK.
  - If no in_val is high: out_val=0, all in_rdy=0, out_msg/out_src don't-care; ptr unchanged.
- LOCK:
  - Outputs: out_val=in_val[gnt_id], out_msg=in_msg[gnt_id], out_src=gnt_id, in_rdy[gnt_id]=out_rdy, other in_rdy=0.
  - Higher-priority newcomers are ignored.
  - On transfer: ptr<=(gnt_id+1) mod N; state<=IDLE (or GAP).
  - If in_val[gnt_id] drops (protocol violation): state<=IDLE, ptr unchanged, no transfer.
- Wrap-around: ptr advances from N-1 to 0. ptr is always < N.
- Fairness: with all requesters permanently valid and out_rdy=1, grant order is 0,1,...,N-1,0,... and each requester waits at most N-1 transfers.
- Latency: 0 cycles in IDLE with out_rdy=1. Messages are never buffered; out_msg is combinational from in_msg.
- Reset mid-operation: the lock and gap are abandoned; nothing is transferred in the reset cycle.

Optional Feature:
VC_TEST_ARB_RAND_GAP_EN
- Defined:
  - Each transfer loads gap counter = {$random} % (p_max_gap+1), a 32-bit value; p_max_gap=0 gives 0.
  - If the loaded value is nonzero, state<=GAP.
  - In GAP: out_val=0, all in_rdy=0; the counter decrements each cycle; at 1, state<=IDLE.
  - Reset clears the counter.
- Undefined: no GAP state, no counter, p_max_gap ignored; the FSM is IDLE/LOCK only.

Test Plan:
- Reset, then all in_val=0 -> out_val=0, in_rdy=0000, ptr=0.
- N=4; in_val=1111, in_msg={0x33,0x22,0x11,0x00}, out_rdy=1 for 8 cycles -> out_src 0,1,2,3,0,1,2,3; out_msg 00,11,22,33,00,11,22,33; one-hot in_rdy each cycle.
- in_val=0100, out_rdy=0 for 3 cycles, in_val[0] raised at cycle 1, then out_rdy=1 -> out_src stays 2 throughout (locked), transfer of 0x22 occurs when out_rdy rises, next grant goes to 0 (ptr=3, 0 wins by wrap).
- ptr=3, in_val=1001 -> requester 3 granted first, then 0 (wrap-around).
- Locked on 1, then in_val[1] dropped -> next cycle state IDLE, no transfer, ptr unchanged.
- With VC_TEST_ARB_RAND_GAP_EN, p_max_gap=3, all valid, out_rdy=1 -> gaps of 0..3 idle cycles between transfers (out_val=0 and in_rdy=0 during gaps); order still 0,1,2,3; reset during a gap -> IDLE next cycle.
